ascii_msg_tx: RTL

ASCII_MSG_TX -- requirements
Module: ascii_msg_tx

---
 rtl/atm_pkg.sv | 30 +++
 rtl/ascii_msg_rom.sv | 35 +++
 rtl/ascii_msg_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared ATM constants: status codes, terminal control characters, message FSM states.
package atm_pkg;

  localparam logic [3:0] ACC_FOUND      = 4'd1;
  localparam logic [3:0] ACC_NOT_FOUND  = 4'd2;
  localparam logic [3:0] PIN_OK         = 4'd3;
  localparam logic [3:0] PIN_BAD        = 4'd4;
  localparam logic [3:0] AMT_OK         = 4'd5;
  localparam logic [3:0] AMT_BAD        = 4'd6;
  localparam logic [3:0] SESSION_END    = 4'd7;
  localparam logic [3:0] INPUT_COMPLETE = 4'd8;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Texts are stored right-justified in a fixed 8-character field.
  localparam int unsigned TEXT_W = 64;

  typedef enum logic [2:0] {StIdle, StText, StVal, StCr, StLf} tx_state_e;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic code_valid(input logic [3:0] code);
    return (code >= ACC_FOUND) && (code <= INPUT_COMPLETE);
  endfunction

endpackage

// File: rtl/ascii_msg_rom.sv
// Combinational text lookup: character at a given index and the text length for a status code.
module ascii_msg_rom
  import atm_pkg::*;
(
  input  logic [3:0] code,
  input  logic [3:0] index,
  output logic [7:0] ch,
  output logic [3:0] text_len
);

  logic [TEXT_W-1:0] text;
  logic [2:0]        pos;

  always_comb begin
    text     = '0;
    text_len = 4'd0;
    case (code)
      ACC_FOUND:      begin text = {8'h00, "ACCT OK"};  text_len = 4'd7; end
      ACC_NOT_FOUND:  begin text = {8'h00, "NO ACCT"};  text_len = 4'd7; end
      PIN_OK:         begin text = {16'h0000, "PIN OK"}; text_len = 4'd6; end
      PIN_BAD:        begin text = {8'h00, "BAD PIN"};  text_len = 4'd7; end
      AMT_OK:         begin text = {16'h0000, "AMT OK"}; text_len = 4'd6; end
      AMT_BAD:        begin text = {8'h00, "BAD AMT"};  text_len = 4'd7; end
      SESSION_END:    begin text = {40'h0, "BYE"};      text_len = 4'd3; end
      INPUT_COMPLETE: begin text = {48'h0, "OK"};       text_len = 4'd2; end
      default:        begin text = '0;                  text_len = 4'd0; end
    endcase

    // First character sits in the most significant occupied byte.
    pos = 3'(text_len - 4'd1 - index);
    ch  = 8'h00;
    if (index < text_len) ch = text[{pos, 3'b000} +: 8];
  end

endmodule

// File: rtl/ascii_msg_tx.sv
// Status-message serializer: text, optional hex value field, then CR LF, one byte per handshake.
// Define VALUE_ECHO_EN to append " XXXX" (msg_val in hex) to ACC_FOUND and AMT_OK messages.
module ascii_msg_tx
  import atm_pkg::*;
#(
  parameter int unsigned MSG_MAX_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_req,
  input  logic [3:0]  msg_code,
  input  logic [15:0] msg_val,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        msg_done
);

  localparam int unsigned CNT_W = $clog2(MSG_MAX_LEN + 6);

  tx_state_e        state_q, state_d;
  logic [3:0]       code_q;
  logic [15:0]      val_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic       accept, fire, echo, last_char;
  logic [7:0] rom_ch;
  logic [3:0] rom_len;

  ascii_msg_rom u_rom (
    .code     (code_q),
    .index    (4'(cnt_q)),
    .ch       (rom_ch),
    .text_len (rom_len)
  );

`ifdef VALUE_ECHO_EN
  assign echo = (code_q == ACC_FOUND) || (code_q == AMT_OK);
`else
  assign echo = 1'b0;
`endif

  assign busy      = (state_q != StIdle);
  assign tx_valid  = busy;
  assign fire      = tx_valid && tx_ready;
  assign msg_done  = done_q;
  assign accept    = (state_q == StIdle) && msg_req && code_valid(msg_code);
  assign last_char = (cnt_q == CNT_W'(rom_len - 4'd1));

  always_comb begin
    tx_data = 8'h00;
    unique case (state_q)
      StText: tx_data = rom_ch;
      StVal: begin
        unique case (cnt_q)
          CNT_W'(1): tx_data = hex_char(val_q[15:12]);
          CNT_W'(2): tx_data = hex_char(val_q[11:8]);
          CNT_W'(3): tx_data = hex_char(val_q[7:4]);
          CNT_W'(4): tx_data = hex_char(val_q[3:0]);
          default:   tx_data = CHAR_SPACE;
        endcase
      end
      StCr:    tx_data = CHAR_CR;
      StLf:    tx_data = CHAR_LF;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StText;
          cnt_d   = '0;
        end
      end
      StText: begin
        if (fire) begin
          if (last_char) begin
            cnt_d   = '0;
            state_d = echo ? StVal : StCr;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StVal: begin
        // Space plus four hex digits: indices 0..4.
        if (fire) begin
          if (cnt_q == CNT_W'(4)) begin
            cnt_d   = '0;
            state_d = StCr;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCr: if (fire) state_d = StLf;
      StLf: begin
        if (fire) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= 4'd0;
      val_q   <= 16'h0000;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (accept) begin
        code_q <= msg_code;
        val_q  <= msg_val;
      end
    end
  end

endmodule
